// File: rtl/dram_responder.sv
// Cycle-accurate responder for a 64K x 4 multiplexed-address DRAM.
// Decodes RAS/CAS/WE/OE into early writes, reads and CBR refresh, checks
// strobe widths and refresh interval, and keeps sticky errors and counters.
module dram_responder #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned MIN_RAS_LOW   = 5,
    parameter int unsigned MIN_RAS_HIGH  = 5,
    parameter int unsigned MIN_CAS_LOW   = 2,
    parameter int unsigned REFRESH_LIMIT = 800
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] ram_addr,
    input  logic                 ram_ras_,
    input  logic                 ram_cas_,
    input  logic                 ram_we_,
    input  logic                 ram_oe_,
    input  logic [3:0]           ram_dq_in,
    output logic [3:0]           ram_dq_out,
    output logic                 ram_dq_oe,
    output logic [3:0]           err,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count,
    output logic [15:0]          ref_count
);

    localparam int unsigned MEM_AW    = 2 * ADDR_BITS;
    localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
    localparam int unsigned TMR_W     = $clog2(REFRESH_LIMIT + 1);

    localparam logic [3:0]       CNT_MAX      = 4'hF;
    localparam logic [3:0]       RAS_LOW_MIN  = 4'(MIN_RAS_LOW);
    localparam logic [3:0]       RAS_HIGH_MIN = 4'(MIN_RAS_HIGH);
    localparam logic [3:0]       CAS_LOW_MIN  = 4'(MIN_CAS_LOW);
    localparam logic [TMR_W-1:0] REF_LIM      = TMR_W'(REFRESH_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        ROW_OPEN,
        COL_OPEN,
        CBR_PEND,
        CBR
    } state_t;

    state_t state, state_nxt;

    logic                 prev_ras, prev_cas, prev_we;
    logic [ADDR_BITS-1:0] row, col;
    logic [3:0]           mem [MEM_DEPTH];
    logic [3:0]           ras_low_cnt, ras_high_cnt, cas_low_cnt;
    logic                 ras_fall_seen;
    logic [TMR_W-1:0]     ref_timer;
    logic                 ref_armed;
    logic                 read_seen;

    logic              ras_fall_c, ras_rise_c, cas_fall_c, cas_rise_c, we_fall_c;
    logic              latch_row_c, latch_col_c, wr_en_c, ref_done_c;
    logic              rd_now_c, col_close_c, late_wr_c;
    logic [MEM_AW-1:0] rd_addr_c, wr_addr_c;

    assign ras_fall_c = prev_ras & ~ram_ras_;
    assign ras_rise_c = ~prev_ras & ram_ras_;
    assign cas_fall_c = prev_cas & ~ram_cas_;
    assign cas_rise_c = ~prev_cas & ram_cas_;
    assign we_fall_c  = prev_we & ~ram_we_;

    // A read sample: column open (or opening now), CAS low, OE low, WE high, RAS still low
    assign rd_now_c = ~ram_cas_ && ~ram_oe_ && ram_we_ && ~ras_rise_c &&
                      ((state == ROW_OPEN && cas_fall_c) || state == COL_OPEN);
    assign col_close_c = (state == COL_OPEN) && (cas_rise_c || ras_rise_c);
    assign late_wr_c   = (state == COL_OPEN) && ~ram_cas_ && we_fall_c;
    assign rd_addr_c   = {row, (state == COL_OPEN) ? col : ram_addr};
    assign wr_addr_c   = {row, ram_addr};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and per-sample control strobes
    always_comb begin
        state_nxt   = state;
        latch_row_c = 1'b0;
        latch_col_c = 1'b0;
        wr_en_c     = 1'b0;
        ref_done_c  = 1'b0;
        case (state)
            IDLE: begin
                if (ras_fall_c) begin
                    if (ram_cas_) begin
                        state_nxt   = ROW_OPEN;
                        latch_row_c = 1'b1;
                    end else begin
                        state_nxt = CBR;
                    end
                end else if (cas_fall_c) begin
                    state_nxt = CBR_PEND;
                end
            end
            ROW_OPEN: begin
                if (ras_rise_c) begin
                    state_nxt = IDLE;
                end else if (cas_fall_c) begin
                    state_nxt   = COL_OPEN;
                    latch_col_c = 1'b1;
                    wr_en_c     = ~ram_we_;
                end
            end
            COL_OPEN: begin
                if (ras_rise_c)      state_nxt = IDLE;
                else if (cas_rise_c) state_nxt = ROW_OPEN;
            end
            CBR_PEND: begin
                if (ras_fall_c)      state_nxt = CBR;
                else if (cas_rise_c) state_nxt = IDLE;
            end
            CBR: begin
                if (ras_rise_c) begin
                    state_nxt  = IDLE;
                    ref_done_c = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Storage array; never reset so contents survive rst
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_addr_c] <= ram_dq_in;
    end

    // Pin history, address latches and saturating strobe-width counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_ras      <= 1'b1;
            prev_cas      <= 1'b1;
            prev_we       <= 1'b1;
            row           <= '0;
            col           <= '0;
            ras_low_cnt   <= '0;
            ras_high_cnt  <= '0;
            cas_low_cnt   <= '0;
            ras_fall_seen <= 1'b0;
        end else begin
            prev_ras <= ram_ras_;
            prev_cas <= ram_cas_;
            prev_we  <= ram_we_;
            if (latch_row_c) row <= ram_addr;
            if (latch_col_c) col <= ram_addr;
            if (ras_fall_c) ras_fall_seen <= 1'b1;
            if (!ram_ras_) begin
                if (ras_fall_c)                ras_low_cnt <= 4'd1;
                else if (ras_low_cnt != CNT_MAX) ras_low_cnt <= ras_low_cnt + 4'd1;
            end else begin
                if (ras_rise_c)                 ras_high_cnt <= 4'd1;
                else if (ras_high_cnt != CNT_MAX) ras_high_cnt <= ras_high_cnt + 4'd1;
            end
            if (!ram_cas_) begin
                if (cas_fall_c)                cas_low_cnt <= 4'd1;
                else if (cas_low_cnt != CNT_MAX) cas_low_cnt <= cas_low_cnt + 4'd1;
            end
        end
    end

    // Refresh interval timer, armed by the first completed CBR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_timer <= '0;
            ref_armed <= 1'b0;
        end else if (ref_done_c) begin
            ref_timer <= '0;
            ref_armed <= 1'b1;
        end else if (ref_armed && ref_timer != REF_LIM) begin
            ref_timer <= ref_timer + TMR_W'(1);
        end
    end

    // Read data path and per-CAS-period read tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_dq_out <= '0;
            ram_dq_oe  <= 1'b0;
            read_seen  <= 1'b0;
        end else begin
            ram_dq_oe <= rd_now_c;
            if (rd_now_c) ram_dq_out <= mem[rd_addr_c];
            if (col_close_c)   read_seen <= 1'b0;
            else if (rd_now_c) read_seen <= 1'b1;
        end
    end

    // Activity counters and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count  <= '0;
            wr_count  <= '0;
            ref_count <= '0;
            err       <= '0;
        end else begin
            if (wr_en_c)                  wr_count  <= wr_count + 16'd1;
            if (col_close_c && read_seen) rd_count  <= rd_count + 16'd1;
            if (ref_done_c)               ref_count <= ref_count + 16'd1;
            if (ras_rise_c && ras_low_cnt < RAS_LOW_MIN) err[0] <= 1'b1;
            if (ras_fall_c && ras_fall_seen && ras_high_cnt < RAS_HIGH_MIN) err[1] <= 1'b1;
            if (cas_rise_c && cas_low_cnt < CAS_LOW_MIN) err[2] <= 1'b1;
            if (late_wr_c || (ref_armed && ref_timer == REF_LIM)) err[3] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dram_responder.sv
// Directed plus randomized bench for dram_responder; expectations come from a
// transaction-level model (address->nibble map, expected counters and errors).
module tb_dram_responder;

    logic        clk;
    logic        rst;
    logic [7:0]  ram_addr;
    logic        ram_ras_, ram_cas_, ram_we_, ram_oe_;
    logic [3:0]  ram_dq_in;
    logic [3:0]  ram_dq_out;
    logic        ram_dq_oe;
    logic [3:0]  err;
    logic [15:0] rd_count, wr_count, ref_count;

    dram_responder dut (
        .clk       (clk),
        .rst       (rst),
        .ram_addr  (ram_addr),
        .ram_ras_  (ram_ras_),
        .ram_cas_  (ram_cas_),
        .ram_we_   (ram_we_),
        .ram_oe_   (ram_oe_),
        .ram_dq_in (ram_dq_in),
        .ram_dq_out(ram_dq_out),
        .ram_dq_oe (ram_dq_oe),
        .err       (err),
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .ref_count (ref_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model
    logic [3:0]  mem_m [logic [15:0]];
    logic [15:0] rd_e, wr_e, ref_e;
    logic [3:0]  err_e;
    bit          seen_fall;
    int          gap_run;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ":err"}, 32'(err), 32'(err_e));
        check({tag, ":rd_count"}, 32'(rd_count), 32'(rd_e));
        check({tag, ":wr_count"}, 32'(wr_count), 32'(wr_e));
        check({tag, ":ref_count"}, 32'(ref_count), 32'(ref_e));
    endtask

    // Drive one sample's worth of pins at a negedge, return at the next negedge
    task automatic cyc(input logic ras, input logic cas, input logic we, input logic oe,
                       input logic [7:0] a, input logic [3:0] d);
        ram_ras_  = ras;
        ram_cas_  = cas;
        ram_we_   = we;
        ram_oe_   = oe;
        ram_addr  = a;
        ram_dq_in = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'($urandom), 4'h0);
        gap_run += n;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 4'h0);
        check("rst:dq_oe", 32'(ram_dq_oe), 32'd0);
        check("rst:dq_out", 32'(ram_dq_out), 32'd0);
        rst_model();
        check_state("rst");
        rst = 1'b0;
        idle(2);
    endtask

    task automatic rst_model();
        err_e = '0; rd_e = '0; wr_e = '0; ref_e = '0;
        seen_fall = 1'b0;
        gap_run = 0;
    endtask

    // Page-mode access: pre cycles row-only, cl cycles CAS low, post cycles RAS low after CAS rise
    task automatic access(input bit wr, input logic [7:0] r, input logic [7:0] c,
                          input logic [3:0] d, input int pre, input int cl, input int post);
        logic [15:0] a;
        a = {r, c};
        if (seen_fall && gap_run < 5) err_e[1] = 1'b1;
        seen_fall = 1'b1;
        gap_run = 0;
        for (int i = 0; i < pre; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, r, 4'h0);
        for (int i = 0; i < cl; i++) begin
            cyc(1'b0, 1'b0, ~wr, wr, c, d);
            if (wr) begin
                check("wr:dq_oe", 32'(ram_dq_oe), 32'd0);
            end else begin
                check("rd:dq_oe", 32'(ram_dq_oe), 32'd1);
                check("rd:dq_out", 32'(ram_dq_out), 32'(mem_m[a]));
            end
        end
        if (wr) begin
            mem_m[a] = d;
            wr_e++;
        end else if (cl > 0) begin
            rd_e++;
        end
        for (int i = 0; i < post; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b1, c, 4'h0);
            if (i == 0) check("close:dq_oe", 32'(ram_dq_oe), 32'd0);
        end
        if (pre + cl + post < 5) err_e[0] = 1'b1;
        if (cl < 2) err_e[2] = 1'b1;
    endtask

    // CAS-before-RAS refresh: CAS low 5 cycles, then RAS low 5 cycles, then release
    task automatic cbr();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'h0);
        gap_run += 5;
        if (seen_fall && gap_run < 5) err_e[1] = 1'b1;
        seen_fall = 1'b1;
        gap_run = 0;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 4'h0);
        ref_e++;
    endtask

    logic [15:0] addrs [8];

    initial begin
        rst = 1'b1;
        ram_ras_ = 1'b1; ram_cas_ = 1'b1; ram_we_ = 1'b1; ram_oe_ = 1'b1;
        ram_addr = '0; ram_dq_in = '0;
        rst_model();
        @(negedge clk);

        // Reset state, then early write of 0xA to row 0x12 col 0x34
        do_reset();
        idle(3);
        access(1'b1, 8'h12, 8'h34, 4'hA, 2, 3, 2);
        idle(5);
        check_state("early_write");

        // Read back the same address
        access(1'b0, 8'h12, 8'h34, 4'h0, 2, 2, 2);
        idle(5);
        check_state("read");

        // Short RAS low, then short precharge before the next access
        access(1'b1, 8'h9A, 8'hBC, 4'h7, 1, 2, 0);
        idle(2);
        access(1'b0, 8'h12, 8'h34, 4'h0, 2, 2, 1);
        idle(5);
        check("short:err", 32'(err), 32'h3);
        check_state("short");
        access(1'b0, 8'h9A, 8'hBC, 4'h0, 2, 2, 1);
        idle(5);
        check_state("short_readback");

        // Late write: WE falls while CAS already low; memory must not change
        do_reset();
        access(1'b1, 8'h56, 8'h78, 4'h3, 2, 2, 2);
        idle(5);
        seen_fall = 1'b1;
        gap_run = 0;
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h56, 4'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h56, 4'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h78, 4'hC);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h78, 4'hC);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h78, 4'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h78, 4'h0);
        err_e[3] = 1'b1;
        idle(5);
        check_state("late_write");
        access(1'b0, 8'h56, 8'h78, 4'h0, 2, 2, 1);
        idle(5);
        check_state("late_readback");

        // Randomized writes/reads over a small address pool with random strobe widths
        do_reset();
        for (int i = 0; i < 8; i++) addrs[i] = 16'($urandom);
        for (int k = 0; k < 40; k++) begin
            bit wr;
            int idx, pre, cl, post;
            if (k < 8) begin
                wr = 1'b1;
                idx = k;
            end else begin
                wr = ($urandom_range(0, 1) == 1);
                idx = int'($urandom_range(0, 7));
            end
            pre  = int'($urandom_range(1, 3));
            cl   = int'($urandom_range(1, 4));
            post = wr ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
            access(wr, addrs[idx][15:8], addrs[idx][7:0], 4'($urandom), pre, cl, post);
            idle(int'($urandom_range(2, 7)));
            check_state("random");
        end

        // CBR refresh, then let the refresh interval expire
        do_reset();
        idle(5);
        cbr();
        idle(1);
        check_state("cbr");
        idle(699);
        check("refresh_not_yet:err", 32'(err), 32'h0);
        idle(110);
        err_e[3] = 1'b1;
        check_state("refresh_overdue");

        // Asynchronous reset in the middle of a read burst
        do_reset();
        access(1'b1, 8'hE1, 8'h0F, 4'h5, 2, 2, 2);
        idle(5);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'hE1, 4'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'hE1, 4'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h0F, 4'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h0F, 4'h0);
        check("midrd:dq_oe_before", 32'(ram_dq_oe), 32'd1);
        check("midrd:dq_out_before", 32'(ram_dq_out), 32'h5);
        #2;
        rst = 1'b1;
        #1;
        check("midrd:dq_oe_async", 32'(ram_dq_oe), 32'd0);
        check("midrd:wr_count_async", 32'(wr_count), 32'd0);
        check("midrd:rd_count_async", 32'(rd_count), 32'd0);
        check("midrd:err_async", 32'(err), 32'd0);
        @(negedge clk);
        do_reset();
        idle(3);
        access(1'b0, 8'hE1, 8'h0F, 4'h0, 2, 2, 1);
        idle(5);
        check_state("post_reset_read");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
